// File: rtl/vote_session_ctrl.sv
// vote_session_ctrl: poll-session sequencer for the voting system.
//
// Opens and closes the poll and admits one voter at a time by ID. It takes
// the first unambiguous (one-hot) candidate pulse from the button
// debouncers and commits it to the has-voted bitmap and the per-candidate
// saturating tally counters.
//
// Optional feature macro: VOTE_TIMEOUT_EN. When defined, an open ballot is
// rejected after TIMEOUT_CYC cycles and the FSM returns to IDLE.
//
// Ports:
//   clock, reset   system clock; synchronous active-high reset
//   poll_start     pulse, open poll (CLOSED only; clears voted + tallies)
//   poll_end       pulse, close poll (IDLE/BALLOT/COMMIT)
//   id_load, id_in pulse + voter ID to admit
//   vote_req       per-candidate valid_vote pulses
//   mode           1 = result mode, vote_req ignored
//   tally_sel      candidate whose tally appears on tally_out
//   pollsig        poll open (IDLE, BALLOT, COMMIT)
//   voter_id       latched current voter ID
//   voted          per-ID has-voted flags
//   ballot_open    high in BALLOT
//   vote_ack       one-cycle pulse, vote committed
//   vote_reject    one-cycle pulse, request refused
//   tally_out      registered tally[tally_sel]
module vote_session_ctrl #(
  parameter int unsigned NUM_CAND    = 4,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned TIMEOUT_CYC = 500000000
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        poll_start,
  input  logic                        poll_end,
  input  logic                        id_load,
  input  logic [7:0]                  id_in,
  input  logic [NUM_CAND-1:0]         vote_req,
  input  logic                        mode,
  input  logic [$clog2(NUM_CAND)-1:0] tally_sel,
  output logic                        pollsig,
  output logic [7:0]                  voter_id,
  output logic [255:0]                voted,
  output logic                        ballot_open,
  output logic                        vote_ack,
  output logic                        vote_reject,
  output logic [CNT_W-1:0]            tally_out
);

  localparam int unsigned SelW = $clog2(NUM_CAND);
  localparam logic [CNT_W-1:0] TallyMax = '1;

  typedef enum logic [1:0] {StClosed, StIdle, StBallot, StCommit} state_e;

  state_e           state_q, state_d;
  logic [7:0]       voter_id_q, voter_id_d;
  logic [255:0]     voted_q, voted_d;
  logic [SelW-1:0]  cand_q, cand_d;
  logic [CNT_W-1:0] tally_q [NUM_CAND];
  logic [CNT_W-1:0] tally_d [NUM_CAND];
  logic             pollsig_q, pollsig_d;
  logic             ballot_open_q, ballot_open_d;
  logic             vote_ack_q, vote_ack_d;
  logic             vote_reject_q, vote_reject_d;
  logic [CNT_W-1:0] tally_out_q, tally_out_d;

  // Request decode: exactly one bit is a vote, two or more is ambiguous.
  logic            req_one;
  logic            req_multi;
  logic [SelW-1:0] req_idx;

  always_comb begin
    req_idx = '0;
    for (int unsigned i = 0; i < NUM_CAND; i++) begin
      if (vote_req[i]) req_idx = SelW'(i);
    end
    req_one   = $onehot(vote_req);
    req_multi = (|vote_req) && !req_one;
  end

  logic timeout;

`ifdef VOTE_TIMEOUT_EN
  localparam int unsigned TmrW = $clog2(TIMEOUT_CYC) + 1;

  logic [TmrW-1:0] timer_q, timer_d;

  // Held at zero outside BALLOT, so every BALLOT entry starts from zero.
  always_comb begin
    timer_d = '0;
    if (state_q == StBallot) timer_d = timer_q + 1'b1;
  end

  assign timeout = (state_q == StBallot) && (timer_q == TmrW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clock) begin
    if (reset) timer_q <= '0;
    else       timer_q <= timer_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    voter_id_d    = voter_id_q;
    voted_d       = voted_q;
    cand_d        = cand_q;
    tally_d       = tally_q;
    vote_ack_d    = 1'b0;
    vote_reject_d = 1'b0;

    unique case (state_q)
      StClosed: begin
        if (poll_start) begin
          state_d = StIdle;
          voted_d = '0;
          for (int unsigned i = 0; i < NUM_CAND; i++) tally_d[i] = '0;
        end
      end
      StIdle: begin
        if (poll_end) begin
          state_d = StClosed;
        end else if (id_load) begin
          if (voted_q[id_in]) begin
            vote_reject_d = 1'b1;
          end else begin
            voter_id_d = id_in;
            state_d    = StBallot;
          end
        end
      end
      StBallot: begin
        if (poll_end) begin
          // Abandoned ballot: no ack, no reject, voted untouched.
          state_d = StClosed;
        end else if (!mode && req_one) begin
          cand_d  = req_idx;
          state_d = StCommit;
        end else begin
          if (!mode && req_multi) vote_reject_d = 1'b1;
          if (timeout) begin
            vote_reject_d = 1'b1;
            state_d       = StIdle;
          end
        end
      end
      StCommit: begin
        // The write always completes, even when poll_end arrives now.
        if (tally_q[cand_q] != TallyMax) tally_d[cand_q] = tally_q[cand_q] + 1'b1;
        voted_d[voter_id_q] = 1'b1;
        vote_ack_d          = 1'b1;
        state_d             = poll_end ? StClosed : StIdle;
      end
      default: state_d = StClosed;
    endcase

    pollsig_d     = (state_d != StClosed);
    ballot_open_d = (state_d == StBallot);
    tally_out_d   = (32'(tally_sel) < NUM_CAND) ? tally_q[tally_sel] : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StClosed;
      voter_id_q    <= '0;
      voted_q       <= '0;
      cand_q        <= '0;
      for (int unsigned i = 0; i < NUM_CAND; i++) tally_q[i] <= '0;
      pollsig_q     <= 1'b0;
      ballot_open_q <= 1'b0;
      vote_ack_q    <= 1'b0;
      vote_reject_q <= 1'b0;
      tally_out_q   <= '0;
    end else begin
      state_q       <= state_d;
      voter_id_q    <= voter_id_d;
      voted_q       <= voted_d;
      cand_q        <= cand_d;
      tally_q       <= tally_d;
      pollsig_q     <= pollsig_d;
      ballot_open_q <= ballot_open_d;
      vote_ack_q    <= vote_ack_d;
      vote_reject_q <= vote_reject_d;
      tally_out_q   <= tally_out_d;
    end
  end

  assign pollsig     = pollsig_q;
  assign voter_id    = voter_id_q;
  assign voted       = voted_q;
  assign ballot_open = ballot_open_q;
  assign vote_ack    = vote_ack_q;
  assign vote_reject = vote_reject_q;
  assign tally_out   = tally_out_q;

endmodule
